// File: rtl/spi_nor_phy.sv
// SPI mode-0 byte serializer/deserializer between the NOR flash controller and the flash pins.
// SCLK is a divided copy of p_clk; chip select is held low across multi-byte transactions.
module spi_nor_phy #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              p_clk,
    input  logic              p_rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int unsigned DIV_W = 8;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned TXS_W = DATA_W - 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_TRAIL = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    logic [2:0]        state_q,   state_d;
    logic [DIV_W-1:0]  div_q,     div_d;
    logic [BIT_W-1:0]  bit_q,     bit_d;
    logic [TXS_W-1:0]  tx_q,      tx_d;
    logic              last_q,    last_d;
    logic [DATA_W-1:0] rx_q,      rx_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              sclk_q,    sclk_d;
    logic              cs_n_q,    cs_n_d;
    logic              mosi_q,    mosi_d;
    logic              busy_q,    busy_d;

    logic              tx_ready_c;
    logic              accept_c;
    logic              div_done_c;
    logic [DATA_W-1:0] rx_next_c;

    // WAIT is entered in the cycle of the final falling edge; ready is held off for that cycle.
    assign tx_ready_c = (state_q == ST_IDLE) || ((state_q == ST_WAIT) && !rx_valid_q);
    assign accept_c   = tx_valid && tx_ready_c;
    assign div_done_c = (div_q == DIV_LAST);

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q + DIV_W'(1);
        bit_d      = bit_q;
        tx_d       = tx_q;
        last_d     = last_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;

        // MISO is captured in the first cycle of each high phase.
        rx_next_c = rx_q;
        if ((state_q == ST_SHIFT) && sclk_q && (div_q == '0)) begin
            rx_next_c = {rx_q[DATA_W-2:0], spi_miso};
        end
        rx_d = rx_next_c;

        case (state_q)
            ST_IDLE, ST_WAIT: begin
                div_d = '0;
                if (accept_c) begin
                    state_d = ST_SETUP;
                    cs_n_d  = 1'b0;
                    mosi_d  = tx_data[DATA_W-1];
                    tx_d    = tx_data[DATA_W-2:0];
                    last_d  = tx_last;
                    bit_d   = '0;
                end
            end
            ST_SETUP: begin
                if (div_done_c) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b1;
                    div_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (div_done_c) begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                    if (sclk_q) begin
                        if (bit_q == BIT_LAST) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = rx_next_c;
                            state_d    = last_q ? ST_TRAIL : ST_WAIT;
                        end else begin
                            bit_d  = bit_q + BIT_W'(1);
                            mosi_d = tx_q[TXS_W-1];
                            tx_d   = tx_q << 1;
                        end
                    end
                end
            end
            ST_TRAIL: begin
                if (div_done_c) begin
                    state_d = ST_GAP;
                    cs_n_d  = 1'b1;
                    div_d   = '0;
                end
            end
            ST_GAP: begin
                if (div_done_c) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                sclk_d  = 1'b0;
                cs_n_d  = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            last_q     <= 1'b0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            last_q     <= last_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready = tx_ready_c;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign spi_sclk = sclk_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_nor_phy.sv
// Directed bench for spi_nor_phy: one DUT at CLK_DIV=2, one at CLK_DIV=1, each with a mode-0 flash slave model.
module tb_spi_nor_phy;

    logic p_clk = 1'b0;
    logic p_rst_n = 1'b0;
    always #5 p_clk = ~p_clk;

    int cyc = 0;
    always @(posedge p_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int t0 = 0;

    // CLK_DIV=2 instance
    logic       tx_valid2 = 1'b0, tx_last2 = 1'b0, tx_ready2, rv2, busy2, sclk2, cs2, mosi2;
    logic       miso2 = 1'b0;
    logic [7:0] tx_data2 = 8'h00, rd2;

    // CLK_DIV=1 instance
    logic       tx_valid1 = 1'b0, tx_last1 = 1'b0, tx_ready1, rv1, busy1, sclk1, cs1, mosi1;
    logic       miso1 = 1'b0;
    logic [7:0] tx_data1 = 8'h00, rd1;

    spi_nor_phy #(.CLK_DIV(2), .DATA_W(8)) dut2 (
        .p_clk(p_clk), .p_rst_n(p_rst_n), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .tx_data(tx_data2), .tx_last(tx_last2), .rx_valid(rv2), .rx_data(rd2), .busy(busy2),
        .spi_sclk(sclk2), .spi_cs_n(cs2), .spi_mosi(mosi2), .spi_miso(miso2)
    );

    spi_nor_phy #(.CLK_DIV(1), .DATA_W(8)) dut1 (
        .p_clk(p_clk), .p_rst_n(p_rst_n), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .tx_data(tx_data1), .tx_last(tx_last1), .rx_valid(rv1), .rx_data(rd1), .busy(busy1),
        .spi_sclk(sclk1), .spi_cs_n(cs1), .spi_mosi(mosi1), .spi_miso(miso1)
    );

    // Slave models and pin monitors, evaluated mid-cycle
    logic [7:0] slave2 [0:7];
    logic [7:0] slave1 [0:7];
    int s2_byte = 8, s2_bit = 7, s1_byte = 8, s1_bit = 7;
    int rise2 = 0, csbad2 = 0, csrise2 = 0, rxcnt2 = 0;
    int rise1 = 0;
    logic [7:0] mosi_cap2 = 8'h00, mosi_cap1 = 8'h00;
    logic prev_cs2 = 1'b1, prev_sclk2 = 1'b0, prev_cs1 = 1'b1, prev_sclk1 = 1'b0;

    always @(negedge p_clk) begin
        if (prev_cs2 && !cs2) begin
            s2_byte = 0; s2_bit = 7;
        end else if (prev_sclk2 && !sclk2) begin
            if (s2_bit == 0) begin s2_byte = s2_byte + 1; s2_bit = 7; end
            else s2_bit = s2_bit - 1;
        end
        if (!prev_sclk2 && sclk2) begin
            rise2 = rise2 + 1;
            mosi_cap2 = {mosi_cap2[6:0], mosi2};
            if (cs2 !== 1'b0) csbad2 = csbad2 + 1;
        end
        if (!prev_cs2 && cs2) csrise2 = csrise2 + 1;
        if (rv2 === 1'b1) rxcnt2 = rxcnt2 + 1;
        miso2 = (s2_byte < 8) ? slave2[s2_byte][s2_bit] : 1'b0;
        prev_cs2 = cs2;
        prev_sclk2 = sclk2;

        if (prev_cs1 && !cs1) begin
            s1_byte = 0; s1_bit = 7;
        end else if (prev_sclk1 && !sclk1) begin
            if (s1_bit == 0) begin s1_byte = s1_byte + 1; s1_bit = 7; end
            else s1_bit = s1_bit - 1;
        end
        if (!prev_sclk1 && sclk1) begin
            rise1 = rise1 + 1;
            mosi_cap1 = {mosi_cap1[6:0], mosi1};
        end
        miso1 = (s1_byte < 8) ? slave1[s1_byte][s1_bit] : 1'b0;
        prev_cs1 = cs1;
        prev_sclk1 = sclk1;
    end

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    task automatic send2(input logic [7:0] d, input logic l);
        int n = 0;
        while (tx_ready2 !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL send2_ready got tx_ready=%b required 1 within 200 cycles", tx_ready2);
        end
        tx_valid2 = 1'b1; tx_data2 = d; tx_last2 = l;
        t0 = cyc;
        tick();
        tx_valid2 = 1'b0;
    endtask

    task automatic wait_rx2(input logic [7:0] exp_rx, input logic [7:0] exp_mosi, input string name);
        int n = 0;
        while (rv2 !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s rx_valid_timeout got rx_valid=%b required 1", name, rv2);
        end
        checks++;
        if ((cyc - t0) !== 33) begin
            errors++;
            $display("FAIL %s rx_latency got %0d required 33", name, cyc - t0);
        end
        checks++;
        if (rd2 !== exp_rx) begin
            errors++;
            $display("FAIL %s rx_data got %h required %h", name, rd2, exp_rx);
        end
        checks++;
        if (mosi_cap2 !== exp_mosi) begin
            errors++;
            $display("FAIL %s mosi_bits got %h required %h", name, mosi_cap2, exp_mosi);
        end
    endtask

    task automatic wait_idle2();
        int n = 0;
        while (busy2 !== 1'b0 && n < 200) begin tick(); n++; end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL idle_timeout got busy=%b required 0", busy2);
        end
    endtask

    task automatic test_reset();
        p_rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({cs2, sclk2, mosi2, rv2, busy2, tx_ready2} !== 6'b100001) begin
            errors++;
            $display("FAIL reset_pins got cs/sclk/mosi/rv/busy/rdy=%b required 100001",
                     {cs2, sclk2, mosi2, rv2, busy2, tx_ready2});
        end
        checks++;
        if (rd2 !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_data got %h required 00", rd2);
        end
        p_rst_n = 1'b1;
        tick(); tick();
        checks++;
        if ({cs2, sclk2, busy2, tx_ready2, cs1, sclk1, busy1, tx_ready1} !== 8'b10011001) begin
            errors++;
            $display("FAIL reset_release got %b required 10011001",
                     {cs2, sclk2, busy2, tx_ready2, cs1, sclk1, busy1, tx_ready1});
        end
    endtask

    task automatic test_single_byte();
        int rb = rise2;
        int cb = csbad2;
        logic [4:0] got, exp;
        slave2[0] = 8'h3C;
        send2(8'hA5, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            exp = {(k >= 3 && k <= 32 && ((k - 3) % 4) < 2), !(k <= 34), (k == 33), (k >= 37), (k <= 36)};
            got = {sclk2, cs2, rv2, tx_ready2, busy2};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL single k=%0d got sclk/cs/rv/rdy/busy=%b required %b", k, got, exp);
            end
            if (k == 33) begin
                checks++;
                if (rd2 !== 8'h3C) begin
                    errors++;
                    $display("FAIL single_rx_data got %h required 3c", rd2);
                end
            end
            tick();
        end
        checks++;
        if ({mosi_cap2, 8'(rise2 - rb), 8'(csbad2 - cb)} !== {8'hA5, 8'd8, 8'd0}) begin
            errors++;
            $display("FAIL single_mosi got mosi=%h rises=%0d csbad=%0d required a5 8 0",
                     mosi_cap2, rise2 - rb, csbad2 - cb);
        end
    endtask

    task automatic test_read_cmd();
        logic [7:0] cmd [0:4];
        int rb = rise2, cb = csbad2, crb = csrise2, rxb = rxcnt2;
        int prev_t0 = 0;
        cmd[0] = 8'h03; cmd[1] = 8'h12; cmd[2] = 8'h34; cmd[3] = 8'h56; cmd[4] = 8'h00;
        slave2[0] = 8'hFF; slave2[1] = 8'h11; slave2[2] = 8'h22; slave2[3] = 8'h33; slave2[4] = 8'hC9;
        for (int i = 0; i < 5; i++) begin
            send2(cmd[i], i == 4);
            if (i > 0) begin
                checks++;
                if ((t0 - prev_t0) !== 34) begin
                    errors++;
                    $display("FAIL read_accept_spacing byte %0d got %0d required 34", i, t0 - prev_t0);
                end
            end
            prev_t0 = t0;
            wait_rx2(slave2[i], cmd[i], "read");
        end
        wait_idle2();
        checks++;
        if ({8'(rise2 - rb), 8'(csbad2 - cb), 8'(csrise2 - crb), 8'(rxcnt2 - rxb), rd2} !==
            {8'd40, 8'd0, 8'd1, 8'd5, 8'hC9}) begin
            errors++;
            $display("FAIL read_summary got rises=%0d csbad=%0d csrise=%0d rx=%0d data=%h required 40 0 1 5 c9",
                     rise2 - rb, csbad2 - cb, csrise2 - crb, rxcnt2 - rxb, rd2);
        end
    endtask

    task automatic test_wait_stall();
        int rb = rise2, crb = csrise2;
        slave2[0] = 8'hA1; slave2[1] = 8'hB2; slave2[2] = 8'hC3;
        send2(8'h11, 1'b0);
        wait_rx2(8'hA1, 8'h11, "stall_b1");
        send2(8'h22, 1'b0);
        wait_rx2(8'hB2, 8'h22, "stall_b2");
        tick();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ({cs2, sclk2, rv2, busy2, tx_ready2} !== 5'b00011) begin
                errors++;
                $display("FAIL stall k=%0d got cs/sclk/rv/busy/rdy=%b required 00011",
                         k, {cs2, sclk2, rv2, busy2, tx_ready2});
            end
            tick();
        end
        send2(8'h33, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if ({cs2, sclk2} !== {1'b0, k == 3}) begin
                errors++;
                $display("FAIL stall_setup k=%0d got cs/sclk=%b required %b", k, {cs2, sclk2}, {1'b0, k == 3});
            end
            if (k < 3) tick();
        end
        wait_rx2(8'hC3, 8'h33, "stall_b3");
        wait_idle2();
        checks++;
        if ({8'(rise2 - rb), 8'(csrise2 - crb)} !== {8'd24, 8'd1}) begin
            errors++;
            $display("FAIL stall_summary got rises=%0d csrise=%0d required 24 1", rise2 - rb, csrise2 - crb);
        end
    endtask

    task automatic test_hold_valid();
        slave2[0] = 8'h5E;
        send2(8'h81, 1'b1);
        tx_valid2 = 1'b1; tx_data2 = 8'hFF; tx_last2 = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            checks++;
            if (tx_ready2 !== 1'b0) begin
                errors++;
                $display("FAIL hold_ready k=%0d got %b required 0", k, tx_ready2);
            end
            if (k == 33) begin
                checks++;
                if ({rv2, rd2, mosi_cap2} !== {1'b1, 8'h5E, 8'h81}) begin
                    errors++;
                    $display("FAIL hold_byte got rv=%b rx=%h mosi=%h required 1 5e 81", rv2, rd2, mosi_cap2);
                end
            end
            tick();
        end
        checks++;
        if (tx_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL hold_ready_idle got %b required 1", tx_ready2);
        end
        t0 = cyc;
        tick();
        tx_valid2 = 1'b0;
        wait_rx2(8'h5E, 8'hFF, "hold_ff");
        wait_idle2();
    endtask

    task automatic test_reset_mid();
        int n = 0, seen = 0, rxb;
        logic prev = 1'b0;
        slave2[0] = 8'h99;
        send2(8'hC3, 1'b1);
        while (seen < 4 && n < 100) begin
            if (sclk2 && !prev) seen++;
            prev = sclk2;
            if (seen < 4) begin tick(); n++; end
        end
        checks++;
        if (seen !== 4) begin
            errors++;
            $display("FAIL rst_mid_rises got %0d required 4", seen);
        end
        p_rst_n = 1'b0;
        #1;
        checks++;
        if ({cs2, sclk2, mosi2, rv2, busy2} !== 5'b10000) begin
            errors++;
            $display("FAIL rst_mid_pins got cs/sclk/mosi/rv/busy=%b required 10000", {cs2, sclk2, mosi2, rv2, busy2});
        end
        rxb = rxcnt2;
        tick(); tick();
        p_rst_n = 1'b1;
        repeat (40) tick();
        checks++;
        if ({8'(rxcnt2 - rxb), rd2, busy2} !== {8'd0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_after got rx=%0d data=%h busy=%b required 0 00 0", rxcnt2 - rxb, rd2, busy2);
        end
        send2(8'h5A, 1'b1);
        wait_rx2(8'h99, 8'h5A, "rst_fresh");
        wait_idle2();
    endtask

    task automatic test_div1();
        logic [3:0] got, exp;
        int rb = rise1;
        slave1[0] = 8'hB4;
        checks++;
        if (tx_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL div1_ready got %b required 1", tx_ready1);
        end
        tx_valid1 = 1'b1; tx_data1 = 8'h0F; tx_last1 = 1'b1;
        tick();
        tx_valid1 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            exp = {(k >= 2 && k <= 16 && (k % 2) == 0), !(k <= 17), (k == 17), (k >= 19)};
            got = {sclk1, cs1, rv1, tx_ready1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL div1 k=%0d got sclk/cs/rv/rdy=%b required %b", k, got, exp);
            end
            if (k == 17) begin
                checks++;
                if (rd1 !== 8'hB4) begin
                    errors++;
                    $display("FAIL div1_rx_data got %h required b4", rd1);
                end
            end
            tick();
        end
        checks++;
        if ({mosi_cap1, 8'(rise1 - rb)} !== {8'h0F, 8'd8}) begin
            errors++;
            $display("FAIL div1_mosi got mosi=%h rises=%0d required 0f 8", mosi_cap1, rise1 - rb);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            slave2[i] = 8'h00;
            slave1[i] = 8'h00;
        end
        test_reset();
        test_single_byte();
        test_read_cmd();
        test_wait_stall();
        test_hold_valid();
        test_reset_mid();
        test_div1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish required finish before 200000ns");
        $fatal(1, "watchdog");
    end

endmodule
